// File: rtl/arm_pkg.sv
// Shared ARM register-bank definitions: mode encodings, controller states and
// physical index bases for the banked registers.
package arm_pkg;
    localparam logic [4:0] MODE_USR = 5'b10000;
    localparam logic [4:0] MODE_FIQ = 5'b10001;
    localparam logic [4:0] MODE_IRQ = 5'b10010;
    localparam logic [4:0] MODE_SVC = 5'b10011;
    localparam logic [4:0] MODE_ABT = 5'b10111;
    localparam logic [4:0] MODE_UND = 5'b11011;
    localparam logic [4:0] MODE_SYS = 5'b11111;

    localparam int FIQ_BASE = 16;
    localparam int SVC_BASE = 23;
    localparam int ABT_BASE = 25;
    localparam int IRQ_BASE = 27;
    localparam int UND_BASE = 29;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PCWR,
        ST_WR,
        ST_RD,
        ST_RCAP,
        ST_RESP
    } state_t;
endpackage

// File: rtl/reg_map.sv
// Combinational logical-to-physical register index map for the current mode.
// SPSR slots (31-36) are never produced.
module reg_map
    import arm_pkg::*;
#(
    parameter int PW = 6
) (
    input  logic [4:0]    mode,
    input  logic [3:0]    lreg,
    output logic [PW-1:0] pidx
);
    function automatic logic [PW-1:0] banked(input logic [3:0] r, input int base);
        return (r == 4'd13 || r == 4'd14) ? PW'(base) + PW'(r - 4'd13) : PW'(r);
    endfunction

    always_comb begin
        pidx = PW'(lreg);
        case (mode)
            MODE_FIQ: if (lreg >= 4'd8 && lreg != 4'd15) pidx = PW'(FIQ_BASE) + PW'(lreg - 4'd8);
            MODE_SVC: pidx = banked(lreg, SVC_BASE);
            MODE_ABT: pidx = banked(lreg, ABT_BASE);
            MODE_IRQ: pidx = banked(lreg, IRQ_BASE);
            MODE_UND: pidx = banked(lreg, UND_BASE);
            default:  pidx = PW'(lreg);
        endcase
    end
endmodule

// File: rtl/regbank_ctrl.sv
// Register-bank port owner: arbitrates PC redirect, ALU/MEM writeback and decode
// reads, maps logical registers by mode and sequences one bank operation per grant.
module regbank_ctrl
    import arm_pkg::*;
#(
    parameter int DW = 32,
    parameter int PW = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [4:0]    mode,
    input  logic          rd_valid_i,
    output logic          rd_ready_o,
    input  logic [3:0]    rd_reg1,
    input  logic [3:0]    rd_reg2,
    output logic          rd_valid_o,
    input  logic          rd_ready_i,
    output logic [DW-1:0] rd_data1,
    output logic [DW-1:0] rd_data2,
    input  logic          alu_wb_valid,
    output logic          alu_wb_ready,
    input  logic [3:0]    alu_wb_reg,
    input  logic [DW-1:0] alu_wb_data,
    input  logic          mem_wb_valid,
    output logic          mem_wb_ready,
    input  logic [3:0]    mem_wb_reg,
    input  logic [DW-1:0] mem_wb_data,
    input  logic          pc_valid,
    input  logic [DW-1:0] pc_data,
    output logic [PW-1:0] bank_addr1,
    output logic [PW-1:0] bank_addr2,
    output logic          bank_we,
    output logic [DW-1:0] bank_wdata,
    output logic          bank_pc_we,
    output logic [DW-1:0] bank_pc_wdata,
    input  logic [DW-1:0] bank_rdata1,
    input  logic [DW-1:0] bank_rdata2
);
    state_t        state, state_nx;
    logic [4:0]    mode_q;
    logic [3:0]    r1_q, r2_q, wreg_q;
    logic [DW-1:0] wdata_q, pc_q;
    logic          pc_pend, gnt_mem_q, last_mem;
    logic [PW-1:0] map1, map2, mapw;
    logic          pc_req, wb_req, pick_mem, eval, resp_hold;

    reg_map #(.PW(PW)) u_map_rd1 (.mode(mode_q), .lreg(r1_q),   .pidx(map1));
    reg_map #(.PW(PW)) u_map_rd2 (.mode(mode_q), .lreg(r2_q),   .pidx(map2));
    reg_map #(.PW(PW)) u_map_wr  (.mode(mode_q), .lreg(wreg_q), .pidx(mapw));

    // A redirect that arrives while busy is parked so it is never lost.
    assign pc_req    = pc_valid | pc_pend;
    assign wb_req    = alu_wb_valid | mem_wb_valid;
    assign pick_mem  = mem_wb_valid & (~alu_wb_valid | ~last_mem);
    assign eval      = (state == ST_IDLE) | ((state == ST_RESP) & ~rd_ready_i);
    assign resp_hold = rd_valid_o & ~rd_ready_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            mode_q     <= '0;
            r1_q       <= '0;
            r2_q       <= '0;
            wreg_q     <= '0;
            wdata_q    <= '0;
            pc_q       <= '0;
            pc_pend    <= 1'b0;
            gnt_mem_q  <= 1'b0;
            last_mem   <= 1'b0;
            rd_valid_o <= 1'b0;
            rd_data1   <= '0;
            rd_data2   <= '0;
        end else begin
            state <= state_nx;
            if (eval && pc_req) pc_pend <= 1'b0;
            else if (pc_valid) begin
                pc_pend <= 1'b1;
                pc_q    <= pc_data;
            end
            if (eval) begin
                mode_q <= mode;
                if (pc_req) wdata_q <= pc_valid ? pc_data : pc_q;
                else if (wb_req) begin
                    gnt_mem_q <= pick_mem;
                    last_mem  <= pick_mem;
                    wreg_q    <= pick_mem ? mem_wb_reg : alu_wb_reg;
                    wdata_q   <= pick_mem ? mem_wb_data : alu_wb_data;
                end else begin
                    r1_q <= rd_reg1;
                    r2_q <= rd_reg2;
                end
            end
            if (state == ST_RCAP) begin
                rd_data1   <= bank_rdata1;
                rd_data2   <= bank_rdata2;
                rd_valid_o <= 1'b1;
            end else if (rd_valid_o && rd_ready_i) rd_valid_o <= 1'b0;
        end
    end

    // Outputs decode from the state register only, so reset clears them at once.
    always_comb begin
        state_nx      = state;
        bank_addr1    = '0;
        bank_addr2    = '0;
        bank_we       = 1'b0;
        bank_wdata    = '0;
        bank_pc_we    = 1'b0;
        bank_pc_wdata = '0;
        rd_ready_o    = 1'b0;
        alu_wb_ready  = 1'b0;
        mem_wb_ready  = 1'b0;
        case (state)
            ST_IDLE, ST_RESP: begin
                if (state == ST_RESP && rd_ready_i) state_nx = ST_IDLE;
                else if (pc_req)                    state_nx = ST_PCWR;
                else if (wb_req)                    state_nx = ST_WR;
                else if (state == ST_IDLE && rd_valid_i) state_nx = ST_RD;
            end
            ST_PCWR: begin
                bank_pc_we    = 1'b1;
                bank_pc_wdata = wdata_q;
                state_nx      = resp_hold ? ST_RESP : ST_IDLE;
            end
            ST_WR: begin
                bank_addr1 = mapw;
                if (wreg_q == 4'd15) begin
                    bank_pc_we    = 1'b1;
                    bank_pc_wdata = wdata_q;
                end else begin
                    bank_we    = 1'b1;
                    bank_wdata = wdata_q;
                end
                mem_wb_ready = gnt_mem_q;
                alu_wb_ready = ~gnt_mem_q;
                state_nx     = resp_hold ? ST_RESP : ST_IDLE;
            end
            ST_RD: begin
                bank_addr1 = map1;
                bank_addr2 = map2;
                rd_ready_o = 1'b1;
                state_nx   = ST_RCAP;
            end
            ST_RCAP: state_nx = ST_RESP;
            default: state_nx = ST_IDLE;
        endcase
    end
endmodule

// File: tb/tb_regbank_ctrl.sv
// Bench for regbank_ctrl: behavioural bank, per-index reference contents and
// directed plus random request sequences.
module tb_regbank_ctrl;
    import arm_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  mode;
    logic        rd_valid_i, rd_ready_o, rd_valid_o, rd_ready_i;
    logic [3:0]  rd_reg1, rd_reg2, alu_wb_reg, mem_wb_reg;
    logic [31:0] rd_data1, rd_data2, alu_wb_data, mem_wb_data, pc_data;
    logic        alu_wb_valid, alu_wb_ready, mem_wb_valid, mem_wb_ready, pc_valid;
    logic [5:0]  bank_addr1, bank_addr2;
    logic        bank_we, bank_pc_we;
    logic [31:0] bank_wdata, bank_pc_wdata, bank_rdata1, bank_rdata2;

    logic [31:0] mem [37];
    logic [31:0] ref_mem [37];
    logic        binit;
    logic [4:0]  mlist [8];
    int n_chk = 0, n_err = 0;

    regbank_ctrl #(.DW(32), .PW(6)) dut (
        .clk(clk), .rst(rst), .mode(mode),
        .rd_valid_i(rd_valid_i), .rd_ready_o(rd_ready_o), .rd_reg1(rd_reg1), .rd_reg2(rd_reg2),
        .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i), .rd_data1(rd_data1), .rd_data2(rd_data2),
        .alu_wb_valid(alu_wb_valid), .alu_wb_ready(alu_wb_ready), .alu_wb_reg(alu_wb_reg),
        .alu_wb_data(alu_wb_data), .mem_wb_valid(mem_wb_valid), .mem_wb_ready(mem_wb_ready),
        .mem_wb_reg(mem_wb_reg), .mem_wb_data(mem_wb_data), .pc_valid(pc_valid), .pc_data(pc_data),
        .bank_addr1(bank_addr1), .bank_addr2(bank_addr2), .bank_we(bank_we), .bank_wdata(bank_wdata),
        .bank_pc_we(bank_pc_we), .bank_pc_wdata(bank_pc_wdata),
        .bank_rdata1(bank_rdata1), .bank_rdata2(bank_rdata2)
    );

    always #5 clk = ~clk;

    // Register bank: synchronous read, PC write lands in slot 15.
    always @(posedge clk) begin
        if (binit) begin
            for (int i = 0; i < 37; i++) mem[i] <= 32'hA000_0000 + i;
        end else begin
            if (bank_we)    mem[bank_addr1] <= bank_wdata;
            if (bank_pc_we) mem[15] <= bank_pc_wdata;
        end
        bank_rdata1 <= mem[bank_addr1];
        bank_rdata2 <= mem[bank_addr2];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Which physical slot a logical register lives in for a given mode.
    function automatic int phys(input logic [4:0] m, input int r);
        int base;
        case (m)
            5'b10011: base = 23;
            5'b10111: base = 25;
            5'b10010: base = 27;
            5'b11011: base = 29;
            default:  base = -1;
        endcase
        if (m == 5'b10001 && r >= 8 && r <= 14) return 16 + (r - 8);
        if (base >= 0 && (r == 13 || r == 14)) return base + (r - 13);
        return r;
    endfunction

    always @(negedge clk)
        if (rst === 1'b0)
            chk("one_op", 64'($countones({bank_we, bank_pc_we, rd_ready_o}) <= 1), 64'd1);

    task automatic idle_out(input string tag);
        chk({tag, "_hs"}, {rd_ready_o, rd_valid_o, alu_wb_ready, mem_wb_ready, bank_we, bank_pc_we}, 0);
        chk({tag, "_addr"}, {bank_addr1, bank_addr2}, 0);
        chk({tag, "_rdat"}, {rd_data1, rd_data2}, 0);
        chk({tag, "_wdat"}, {bank_wdata, bank_pc_wdata}, 0);
    endtask

    // All request tasks start and end just after a rising edge.
    task automatic do_wb(input bit is_mem, input logic [4:0] m, input logic [3:0] r,
                         input logic [31:0] d, input bit scr);
        int cnt = 0, p;
        bit got = 0;
        mode = m;
        p = phys(m, int'(r));
        if (is_mem) begin mem_wb_valid = 1; mem_wb_reg = r; mem_wb_data = d; end
        else begin alu_wb_valid = 1; alu_wb_reg = r; alu_wb_data = d; end
        while (!got && cnt < 10) begin
            @(negedge clk); cnt++;
            if (is_mem ? mem_wb_ready : alu_wb_ready) got = 1;
            else begin @(posedge clk); #1; if (scr) mode = 5'($urandom); end
        end
        chk("wb_lat", cnt, 2);
        if (got) begin
            if (r == 4'd15) begin
                chk("wb_pc_en", {bank_we, bank_pc_we}, 2'b01);
                chk("wb_pc_d", bank_pc_wdata, d);
            end else begin
                chk("wb_en", {bank_we, bank_pc_we}, 2'b10);
                chk("wb_addr", bank_addr1, p);
                chk("wb_d", bank_wdata, d);
            end
            chk("wb_other_rdy", is_mem ? alu_wb_ready : mem_wb_ready, 0);
            ref_mem[p] = d;
        end
        @(posedge clk); #1;
        alu_wb_valid = 0; mem_wb_valid = 0;
        @(negedge clk);
        chk("wb_one_cyc", {bank_we, bank_pc_we}, 0);
        @(posedge clk); #1;
    endtask

    task automatic do_pc(input logic [31:0] d);
        int cnt = 0;
        bit got = 0;
        pc_valid = 1; pc_data = d;
        while (!got && cnt < 10) begin
            @(negedge clk); cnt++;
            if (bank_pc_we) got = 1;
            else begin @(posedge clk); #1; pc_valid = 0; pc_data = $urandom; end
        end
        pc_valid = 0;
        chk("pc_lat", cnt, 2);
        chk("pc_d", bank_pc_wdata, d);
        chk("pc_no_we", bank_we, 0);
        if (got) ref_mem[15] = d;
        @(posedge clk); #1;
        @(negedge clk);
        chk("pc_one_cyc", bank_pc_we, 0);
        @(posedge clk); #1;
    endtask

    task automatic do_rd(input logic [4:0] m, input logic [3:0] r1, input logic [3:0] r2,
                         input bit scr, input int hold);
        int cnt = 0, p1, p2;
        bit got = 0;
        logic [31:0] e1, e2;
        mode = m;
        p1 = phys(m, int'(r1)); p2 = phys(m, int'(r2));
        e1 = ref_mem[p1]; e2 = ref_mem[p2];
        rd_valid_i = 1; rd_reg1 = r1; rd_reg2 = r2;
        while (!got && cnt < 10) begin
            @(negedge clk); cnt++;
            if (rd_ready_o) got = 1;
            else begin @(posedge clk); #1; if (scr) mode = 5'($urandom); end
        end
        chk("rd_lat", cnt, 2);
        chk("rd_addr1", bank_addr1, p1);
        chk("rd_addr2", bank_addr2, p2);
        @(posedge clk); #1;
        rd_valid_i = 0;
        if (scr) mode = 5'($urandom);
        @(negedge clk);
        chk("rd_v_t1", rd_valid_o, 0);
        @(negedge clk);
        chk("rd_v_t2", rd_valid_o, 1);
        chk("rd_d1", rd_data1, e1);
        chk("rd_d2", rd_data2, e2);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            chk("rd_hold", {rd_valid_o, rd_data1, rd_data2}, {1'b1, e1, e2});
        end
        @(posedge clk); #1;
        rd_ready_i = 1;
        @(posedge clk); #1;
        rd_ready_i = 0;
        @(negedge clk);
        chk("rd_drop", rd_valid_o, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] seq;
        int g;
        bit done;
        bit mr, rr;
        mlist = '{MODE_USR, MODE_FIQ, MODE_IRQ, MODE_SVC, MODE_ABT, MODE_UND, MODE_SYS, 5'b01010};
        for (int i = 0; i < 37; i++) ref_mem[i] = 32'hA000_0000 + i;
        rst = 1; binit = 1; mode = MODE_USR;
        rd_valid_i = 0; rd_ready_i = 0; rd_reg1 = 0; rd_reg2 = 0;
        alu_wb_valid = 0; alu_wb_reg = 0; alu_wb_data = 0;
        mem_wb_valid = 0; mem_wb_reg = 0; mem_wb_data = 0;
        pc_valid = 0; pc_data = 0;
        repeat (2) @(posedge clk);
        #1 binit = 0;
        @(negedge clk);
        idle_out("rst");
        @(posedge clk); #1 rst = 0;

        // Reset in the middle of a write
        alu_wb_valid = 1; alu_wb_reg = 4'd4; alu_wb_data = 32'h1234_5678;
        @(negedge clk); @(negedge clk);
        chk("mid_we_pre", bank_we, 1);
        #1 rst = 1;
        #1 chk("mid_we_async", bank_we, 0);
        alu_wb_valid = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        idle_out("post_rst");
        chk("no_partial", mem[4], ref_mem[4]);
        @(posedge clk); #1;

        // Round-robin with both writebacks held
        mode = MODE_USR; seq = 0; g = 0;
        alu_wb_valid = 1; alu_wb_reg = 4'd1; alu_wb_data = $urandom;
        mem_wb_valid = 1; mem_wb_reg = 4'd2; mem_wb_data = $urandom;
        for (int c = 0; c < 20 && g < 4; c++) begin
            @(negedge clk);
            mr = mem_wb_ready; rr = alu_wb_ready;
            if (mr) begin
                seq = {seq[23:0], "M"};
                chk("rr_wd_m", {bank_addr1, bank_wdata}, {6'd2, mem_wb_data});
                ref_mem[2] = mem_wb_data;
            end
            if (rr) begin
                seq = {seq[23:0], "A"};
                chk("rr_wd_a", {bank_addr1, bank_wdata}, {6'd1, alu_wb_data});
                ref_mem[1] = alu_wb_data;
            end
            @(posedge clk); #1;
            if (mr) begin g++; mem_wb_data = $urandom; end
            if (rr) begin g++; alu_wb_data = $urandom; end
        end
        alu_wb_valid = 0; mem_wb_valid = 0;
        chk("rr_order", seq, "MAMA");
        @(posedge clk); #1;

        do_rd(MODE_USR, 4'd3, 4'd15, 0, 1);
        do_wb(0, MODE_FIQ, 4'd9, 32'hDEAD_BEEF, 0);
        do_rd(MODE_USR, 4'd9, 4'd9, 0, 0);

        // PC, MEM writeback and read presented together
        mode = MODE_USR; seq = 0; done = 0;
        pc_valid = 1; pc_data = 32'h100;
        mem_wb_valid = 1; mem_wb_reg = 4'd5; mem_wb_data = 32'h55AA_1234;
        rd_valid_i = 1; rd_reg1 = 4'd5; rd_reg2 = 4'd15;
        for (int c = 0; c < 16 && !done; c++) begin
            @(negedge clk);
            if (bank_pc_we) seq = {seq[23:0], "P"};
            if (bank_we)    seq = {seq[23:0], "W"};
            if (rd_ready_o) seq = {seq[23:0], "R"};
            if (rd_valid_o) done = 1;
            mr = mem_wb_ready; rr = rd_ready_o;
            @(posedge clk); #1;
            pc_valid = 0;
            if (mr) mem_wb_valid = 0;
            if (rr) rd_valid_i = 0;
        end
        chk("ord_seq", seq, "PWR");
        chk("ord_done", done, 1);
        chk("ord_d1", rd_data1, 32'h55AA_1234);
        chk("ord_d2", rd_data2, 32'h100);
        ref_mem[5] = 32'h55AA_1234; ref_mem[15] = 32'h100;
        mem_wb_valid = 0; rd_valid_i = 0;
        rd_ready_i = 1;
        @(posedge clk); #1 rd_ready_i = 0;
        @(posedge clk); #1;

        do_wb(1, MODE_USR, 4'd15, 32'h200, 0);
        do_rd(MODE_SVC, 4'd13, 4'd15, 0, 0);

        for (int i = 0; i < 60; i++) begin
            logic [4:0] m;
            m = mlist[$urandom_range(0, 7)];
            case ($urandom_range(0, 3))
                0: do_wb(0, m, 4'($urandom), $urandom, 1'($urandom));
                1: do_wb(1, m, 4'($urandom), $urandom, 1'($urandom));
                2: do_pc($urandom);
                default: do_rd(m, 4'($urandom), 4'($urandom), 1'($urandom), $urandom_range(0, 2));
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
